// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if -- bundle of the signals between the UART receive
// controller and its surroundings (tick consumer, receiver, processor).
//
//   enable      tick generator run enable
//   baudDiv     tick period minus one, in clk cycles
//   rxDoneTick  one-cycle pulse from the receiver: rxData is complete
//   rxData      received character
//   rdReq       processor read request
//   clrStat     clear the sticky overrun/underflow flags
//   sTick       16x oversampling tick to the receiver
//   rdData      character returned to the processor
//   rdValid     one-cycle strobe: rdData is valid
//   status      {overrun, underflow, empty, count[4:0]}
//
// master: the side driving the controller's inputs; slave: the controller.
interface uart_rx_ctrl_if #(
    parameter int dataBits = 8,
    parameter int divLen   = 8
);
    logic                enable;
    logic [divLen-1:0]   baudDiv;
    logic                rxDoneTick;
    logic [dataBits-1:0] rxData;
    logic                rdReq;
    logic                clrStat;
    logic                sTick;
    logic [dataBits-1:0] rdData;
    logic                rdValid;
    logic [7:0]          status;

    modport master (
        output enable, baudDiv, rxDoneTick, rxData, rdReq, clrStat,
        input  sTick, rdData, rdValid, status
    );

    modport slave (
        input  enable, baudDiv, rxDoneTick, rxData, rdReq, clrStat,
        output sTick, rdData, rdValid, status
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receive-side controller.
//   * Oversampling tick generator: sTick every (baudDiv+1) enabled cycles.
//   * Circular receive buffer fed by rxDoneTick/rxData, sticky overrun.
//   * Read FSM (IDLE -> POP -> ACK): one character per rdReq, rdValid in
//     ACK, sticky underflow when reading an empty buffer.
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high
//   bus    uart_rx_ctrl_if.slave (see interface file for signal list)
module uart_rx_ctrl #(
    parameter int dataBits      = 8,
    parameter int fifoDepth     = 16,
    parameter int fifoCntrWidth = 5,
    parameter int divLen        = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_ctrl_if.slave  bus
);

    localparam int PtrW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        ACK  = 2'd2
    } rd_state_e;

    rd_state_e               state_q, state_d;
    logic [divLen-1:0]       tick_cnt_q, tick_cnt_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [fifoCntrWidth-1:0] count_q, count_d;
    logic [dataBits-1:0]     rd_data_q, rd_data_d;
    logic                    overrun_q, overrun_d;
    logic                    underflow_q, underflow_d;
    logic [dataBits-1:0]     mem [fifoDepth];

    logic s_tick, rd_valid, full, empty, push, pop, underflow_set;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(fifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- tick generator ----------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        tick_cnt_d = '0;
        s_tick     = 1'b0;
        if (bus.enable) begin
            // >= rather than == so a baudDiv lowered below the running
            // count wraps immediately instead of counting all the way round.
            if (tick_cnt_q >= bus.baudDiv) begin
                s_tick = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- buffer bookkeeping ----------------
    assign full  = (count_q == fifoCntrWidth'(fifoDepth));
    assign empty = (count_q == '0);
    assign push  = bus.rxDoneTick && !full;

    // ---------------- read FSM ----------------
    always_comb begin
        state_d       = state_q;
        rd_data_d     = rd_data_q;
        pop           = 1'b0;
        underflow_set = 1'b0;
        rd_valid      = 1'b0;
        case (state_q)
            IDLE: if (bus.rdReq) state_d = POP;
            POP: begin
                // Decision uses the pre-edge count, so a push landing in
                // the same cycle as a pop of an empty buffer still underflows.
                state_d = ACK;
                if (!empty) begin
                    rd_data_d = mem[rd_ptr_q];
                    pop       = 1'b1;
                end else begin
                    rd_data_d     = '0;
                    underflow_set = 1'b1;
                end
            end
            ACK: begin
                rd_valid = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Set has priority over clear so an event coinciding with clrStat
        // is never lost.
        overrun_d   = (overrun_q && !bus.clrStat) || (bus.rxDoneTick && full);
        underflow_d = (underflow_q && !bus.clrStat) || underflow_set;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            overrun_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            overrun_q   <= overrun_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset; after reset its contents are
    // unreachable because the pointers and count restart at zero.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.rxData;
    end

    assign bus.sTick   = s_tick;
    assign bus.rdData  = rd_data_q;
    assign bus.rdValid = rd_valid;
    assign bus.status  = {overrun_q, underflow_q, empty, 5'(count_q)};

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl -- directed self-checking bench for uart_rx_ctrl.
// Inputs change 1 ns after the rising edge; outputs are sampled there or
// on the falling edge.
module tb_uart_rx_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] model_q[$];

    uart_rx_ctrl_if #(.dataBits(8), .divLen(8)) bus ();

    uart_rx_ctrl #(
        .dataBits(8), .fifoDepth(16), .fifoCntrWidth(5), .divLen(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.rxDoneTick = 1'b1;
        bus.rxData     = d;
        tick();
        bus.rxDoneTick = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [7:0] exp_data);
        bus.rdReq = 1'b1;
        tick();                       // now in POP
        bus.rdReq = 1'b0;
        check({tag, "_nvalid_pop"}, 32'(bus.rdValid), 32'd0);
        tick();                       // now in ACK
        check({tag, "_valid"}, 32'(bus.rdValid), 32'd1);
        check({tag, "_data"}, 32'(bus.rdData), 32'(exp_data));
        tick();                       // back to IDLE
        check({tag, "_nvalid_idle"}, 32'(bus.rdValid), 32'd0);
    endtask

    task automatic clear_status();
        bus.clrStat = 1'b1;
        tick();
        bus.clrStat = 1'b0;
    endtask

    initial begin
        logic [7:0] exp;
        bus.enable     = 1'b0;
        bus.baudDiv    = '0;
        bus.rxDoneTick = 1'b0;
        bus.rxData     = '0;
        bus.rdReq      = 1'b0;
        bus.clrStat    = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_status", 32'(bus.status), 32'h20);
        check("rst_rdvalid", 32'(bus.rdValid), 32'd0);
        check("rst_rddata", 32'(bus.rdData), 32'd0);
        check("rst_stick", 32'(bus.sTick), 32'd0);
        reset = 1'b0;
        tick();

        // ---- tick generator, baudDiv=3 ----
        bus.enable  = 1'b1;
        bus.baudDiv = 8'd3;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("tick_div3_%0d", k), 32'(bus.sTick), 32'((k % 4) == 3));
        end
        bus.enable = 1'b0;
        #1;
        check("tick_disable_now", 32'(bus.sTick), 32'd0);
        tick();
        tick();
        check("tick_disable_hold", 32'(bus.sTick), 32'd0);
        // Counter must restart from 0 after being disabled.
        bus.enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("tick_restart_%0d", k), 32'(bus.sTick), 32'(k == 3));
        end
        tick();
        bus.enable = 1'b0;
        tick();
        // baudDiv=0: tick every enabled cycle.
        bus.baudDiv = 8'd0;
        bus.enable  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("tick_div0_%0d", k), 32'(bus.sTick), 32'd1);
        end
        tick();
        bus.enable = 1'b0;
        tick();
        // Lower baudDiv below the running count: wraps on this cycle.
        bus.baudDiv = 8'd7;
        bus.enable  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("tick_div7_%0d", k), 32'(bus.sTick), 32'd0);
        end
        bus.baudDiv = 8'd2;
        #1;
        check("tick_lowered", 32'(bus.sTick), 32'd1);
        @(negedge clk);
        check("tick_after_wrap", 32'(bus.sTick), 32'd0);
        bus.enable = 1'b0;
        tick();

        // ---- push / read ----
        push(8'hA5);
        push(8'h3C);
        check("pr_status2", 32'(bus.status), 32'h02);
        do_read("pr_rd0", 8'hA5);
        do_read("pr_rd1", 8'h3C);
        check("pr_status_end", 32'(bus.status), 32'h20);

        // ---- full / overrun ----
        for (int i = 0; i < 17; i++) push(8'(i));
        check("full_status", 32'(bus.status), 32'h90);
        for (int i = 0; i < 16; i++) do_read($sformatf("full_rd%0d", i), 8'(i));
        check("full_drained", 32'(bus.status), 32'hA0);
        clear_status();
        check("full_cleared", 32'(bus.status), 32'h20);

        // ---- underflow ----
        do_read("uf_rd", 8'h00);
        check("uf_status", 32'(bus.status), 32'h60);
        clear_status();
        check("uf_cleared", 32'(bus.status), 32'h20);
        // clrStat coinciding with an underflow: set wins.
        bus.rdReq = 1'b1;
        tick();
        bus.rdReq   = 1'b0;
        bus.clrStat = 1'b1;
        tick();
        bus.clrStat = 1'b0;
        check("uf_clr_race", 32'(bus.status), 32'h60);
        tick();
        clear_status();
        // Push into empty buffer during POP: underflow, character kept.
        bus.rdReq = 1'b1;
        tick();
        bus.rdReq = 1'b0;
        push(8'h77);
        check("lp_valid", 32'(bus.rdValid), 32'd1);
        check("lp_data", 32'(bus.rdData), 32'h00);
        check("lp_status", 32'(bus.status), 32'h41);
        tick();
        do_read("lp_rd", 8'h77);
        check("lp_status_end", 32'(bus.status), 32'h60);
        clear_status();

        // ---- simultaneous push/pop across pointer wrap ----
        for (int i = 0; i < 5; i++) begin
            push(8'h50 + 8'(i));
            model_q.push_back(8'h50 + 8'(i));
        end
        check("sim_status5", 32'(bus.status), 32'h05);
        for (int i = 0; i < 21; i++) begin
            bus.rdReq = 1'b1;
            tick();
            bus.rdReq = 1'b0;
            model_q.push_back(8'h80 + 8'(i));
            push(8'h80 + 8'(i));
            exp = model_q.pop_front();
            check($sformatf("sim_valid%0d", i), 32'(bus.rdValid), 32'd1);
            check($sformatf("sim_data%0d", i), 32'(bus.rdData), 32'(exp));
            check($sformatf("sim_status%0d", i), 32'(bus.status), 32'h05);
            tick();
        end

        // ---- reset during POP with count=3 ----
        for (int i = 0; i < 2; i++) begin
            exp = model_q.pop_front();
            do_read($sformatf("rs_pre%0d", i), exp);
        end
        check("rs_status3", 32'(bus.status), 32'h03);
        bus.rdReq = 1'b1;
        tick();
        bus.rdReq = 1'b0;
        reset = 1'b1;
        #1;
        check("rs_async_status", 32'(bus.status), 32'h20);
        check("rs_async_valid", 32'(bus.rdValid), 32'd0);
        check("rs_async_data", 32'(bus.rdData), 32'd0);
        tick();
        check("rs_hold_valid", 32'(bus.rdValid), 32'd0);
        tick();
        reset = 1'b0;
        model_q.delete();
        tick();
        check("rs_after_valid", 32'(bus.rdValid), 32'd0);
        check("rs_after_status", 32'(bus.status), 32'h20);
        push(8'hC3);
        do_read("rs_resume", 8'hC3);
        check("rs_resume_status", 32'(bus.status), 32'h20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
